// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg : video timing sets, region bundle and total helpers         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

    localparam int MAX_TOTAL = 2048;

    localparam int VGA640_H_ACTIVE  = 640;
    localparam int VGA640_H_FP      = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BP      = 48;
    localparam int VGA640_V_ACTIVE  = 480;
    localparam int VGA640_V_FP      = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BP      = 33;

    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    localparam int XGA1024_H_ACTIVE = 1024;
    localparam int XGA1024_H_FP     = 24;
    localparam int XGA1024_H_SYNC   = 136;
    localparam int XGA1024_H_BP     = 160;
    localparam int XGA1024_V_ACTIVE = 768;
    localparam int XGA1024_V_FP     = 3;
    localparam int XGA1024_V_SYNC   = 6;
    localparam int XGA1024_V_BP     = 29;

    // 640x480 and 1024x768 use negative syncs; 800x600 uses positive syncs
    localparam bit VGA640_HS_ACTIVE_HIGH  = 1'b0;
    localparam bit VGA640_VS_ACTIVE_HIGH  = 1'b0;
    localparam bit SVGA800_HS_ACTIVE_HIGH = 1'b1;
    localparam bit SVGA800_VS_ACTIVE_HIGH = 1'b1;
    localparam bit XGA1024_HS_ACTIVE_HIGH = 1'b0;
    localparam bit XGA1024_VS_ACTIVE_HIGH = 1'b0;

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
    } region_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_delay_line : enable-gated shift register, async clear to preset  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_delay_line #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_passthru
            logic w_unused;
            assign w_unused = ^{clk, rst, en};
            assign q        = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i];
                end
                if (en) begin
                    stage_d[0] = d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_gen : parametrised video timing with latency-matched RGB  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE       = VGA640_H_ACTIVE,
    parameter int H_FP           = VGA640_H_FP,
    parameter int H_SYNC         = VGA640_H_SYNC,
    parameter int H_BP           = VGA640_H_BP,
    parameter int V_ACTIVE       = VGA640_V_ACTIVE,
    parameter int V_FP           = VGA640_V_FP,
    parameter int V_SYNC         = VGA640_V_SYNC,
    parameter int V_BP           = VGA640_V_BP,
    parameter int CLK_DIV        = 2,
    parameter int PIX_LATENCY    = 2,
    parameter int COLOR_W        = 8,
    parameter bit HS_ACTIVE_HIGH = VGA640_HS_ACTIVE_HIGH,
    parameter bit VS_ACTIVE_HIGH = VGA640_VS_ACTIVE_HIGH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic [10:0]        x,
    output logic [10:0]        y,
    output logic               pix_ce,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic               vga_clk
);

    localparam int          c_h_total     = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int          c_v_total     = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [10:0] c_h_last      = 11'(c_h_total - 1);
    localparam logic [10:0] c_v_last      = 11'(c_v_total - 1);
    localparam logic [11:0] c_h_act       = 12'(H_ACTIVE);
    localparam logic [11:0] c_hs_start    = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_hs_end      = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_v_act       = 12'(V_ACTIVE);
    localparam logic [11:0] c_vs_start    = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_vs_end      = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  c_div_last    = 4'(CLK_DIV - 1);
    localparam logic [3:0]  c_div_half    = 4'(CLK_DIV / 2);
    localparam logic        c_hs_inactive = ~HS_ACTIVE_HIGH;
    localparam logic        c_vs_inactive = ~VS_ACTIVE_HIGH;
    localparam region_t     c_region_rst  = '{hblank: 1'b1, vblank: 1'b1, hsync: 1'b0, vsync: 1'b0};

    generate
        if (c_h_total > MAX_TOTAL || c_v_total > MAX_TOTAL) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
        end
        if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be 2..16");
        end
        if (PIX_LATENCY < 0 || PIX_LATENCY > 8) begin : g_bad_lat
            $error("vga_timing_gen: PIX_LATENCY must be 0..8");
        end
    endgenerate

    logic [3:0]           dcnt_q,    dcnt_d;
    logic                 pix_ce_q,  pix_ce_d;
    logic                 vga_clk_q, vga_clk_d;
    logic [10:0]          x_q,       x_d;
    logic [10:0]          y_q,       y_d;
    logic [3*COLOR_W-1:0] rgb_q,     rgb_d;
    logic                 hs_q,      hs_d;
    logic                 vs_q,      vs_d;
    logic                 blank_n_q, blank_n_d;
    logic                 sync_n_q,  sync_n_d;

    region_t w_region;
    region_t w_region_dly;
    logic    w_blank_dly;

    always_comb begin
        w_region.hblank = {1'b0, x_q} >= c_h_act;
        w_region.vblank = {1'b0, y_q} >= c_v_act;
        w_region.hsync  = ({1'b0, x_q} >= c_hs_start) && ({1'b0, x_q} < c_hs_end);
        w_region.vsync  = ({1'b0, y_q} >= c_vs_start) && ({1'b0, y_q} < c_vs_end);
    end

    // The final output register is the last alignment stage, so only
    // PIX_LATENCY stages live in the delay line itself.
    vga_delay_line #(
        .WIDTH     ($bits(region_t)),
        .DEPTH     (PIX_LATENCY),
        .RESET_VAL (c_region_rst)
    ) u_align (
        .clk (clk),
        .rst (rst),
        .en  (pix_ce_q),
        .d   (w_region),
        .q   (w_region_dly)
    );

    assign w_blank_dly = w_region_dly.hblank | w_region_dly.vblank;

    always_comb begin
        dcnt_d    = (dcnt_q == c_div_last) ? 4'd0 : dcnt_q + 4'd1;
        pix_ce_d  = (dcnt_q == c_div_last);
        vga_clk_d = (dcnt_q >= c_div_half);
        x_d       = x_q;
        y_d       = y_q;
        rgb_d     = rgb_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        sync_n_d  = sync_n_q;
        if (pix_ce_q) begin
            if (x_q == c_h_last) begin
                x_d = 11'd0;
                y_d = (y_q == c_v_last) ? 11'd0 : y_q + 11'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
            rgb_d     = w_blank_dly ? '0 : {r_in, g_in, b_in};
            hs_d      = w_region_dly.hsync ^ c_hs_inactive;
            vs_d      = w_region_dly.vsync ^ c_vs_inactive;
            blank_n_d = ~w_blank_dly;
            sync_n_d  = ~(w_region_dly.hsync | w_region_dly.vsync);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt_q    <= 4'd0;
            pix_ce_q  <= 1'b0;
            vga_clk_q <= 1'b0;
            x_q       <= 11'd0;
            y_q       <= 11'd0;
            rgb_q     <= '0;
            hs_q      <= c_hs_inactive;
            vs_q      <= c_vs_inactive;
            blank_n_q <= 1'b0;
            sync_n_q  <= 1'b1;
        end else begin
            dcnt_q    <= dcnt_d;
            pix_ce_q  <= pix_ce_d;
            vga_clk_q <= vga_clk_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            sync_n_q  <= sync_n_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pix_ce      = pix_ce_q;
    assign vga_clk     = vga_clk_q;
    assign active      = rst & ~w_region.hblank & ~w_region.vblank;
    assign line_start  = pix_ce_q & (x_q == 11'd0);
    assign frame_start = line_start & (y_q == 11'd0);
    assign {vga_r, vga_g, vga_b} = rgb_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = sync_n_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_timing_gen : three timing configurations against a tick model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_timing_gen;

    localparam int NDUT = 3;
    // dut0: default 640x480, dut1: 800x600 div4 lat0 positive syncs, dut2: tiny frame div3 lat8
    localparam int CFG_D    [NDUT] = '{2, 4, 3};
    localparam int CFG_L    [NDUT] = '{2, 0, 8};
    localparam int CFG_HA   [NDUT] = '{640, 800, 12};
    localparam int CFG_HF   [NDUT] = '{16, 40, 2};
    localparam int CFG_HS   [NDUT] = '{96, 128, 3};
    localparam int CFG_HB   [NDUT] = '{48, 88, 3};
    localparam int CFG_VA   [NDUT] = '{480, 600, 5};
    localparam int CFG_VF   [NDUT] = '{10, 1, 1};
    localparam int CFG_VS   [NDUT] = '{2, 4, 2};
    localparam int CFG_VB   [NDUT] = '{33, 23, 1};
    localparam bit CFG_HPOL [NDUT] = '{1'b0, 1'b1, 1'b0};
    localparam bit CFG_VPOL [NDUT] = '{1'b0, 1'b1, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  r_in [NDUT];
    logic [7:0]  g_in [NDUT];
    logic [7:0]  b_in [NDUT];
    logic [10:0] ox [NDUT];
    logic [10:0] oy [NDUT];
    logic        o_pix_ce [NDUT];
    logic        o_active [NDUT];
    logic        o_line [NDUT];
    logic        o_frame [NDUT];
    logic [7:0]  o_r [NDUT];
    logic [7:0]  o_g [NDUT];
    logic [7:0]  o_b [NDUT];
    logic        o_hs [NDUT];
    logic        o_vs [NDUT];
    logic        o_blank_n [NDUT];
    logic        o_sync_n [NDUT];
    logic        o_vclk [NDUT];

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          k      = 0;
    logic [23:0] drv [NDUT];

    always #5 clk = ~clk;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst(rst), .r_in(r_in[0]), .g_in(g_in[0]), .b_in(b_in[0]),
        .x(ox[0]), .y(oy[0]), .pix_ce(o_pix_ce[0]), .active(o_active[0]),
        .line_start(o_line[0]), .frame_start(o_frame[0]),
        .vga_r(o_r[0]), .vga_g(o_g[0]), .vga_b(o_b[0]), .vga_hs(o_hs[0]), .vga_vs(o_vs[0]),
        .vga_blank_n(o_blank_n[0]), .vga_sync_n(o_sync_n[0]), .vga_clk(o_vclk[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .CLK_DIV(4), .PIX_LATENCY(0), .COLOR_W(8),
        .HS_ACTIVE_HIGH(1'b1), .VS_ACTIVE_HIGH(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .r_in(r_in[1]), .g_in(g_in[1]), .b_in(b_in[1]),
        .x(ox[1]), .y(oy[1]), .pix_ce(o_pix_ce[1]), .active(o_active[1]),
        .line_start(o_line[1]), .frame_start(o_frame[1]),
        .vga_r(o_r[1]), .vga_g(o_g[1]), .vga_b(o_b[1]), .vga_hs(o_hs[1]), .vga_vs(o_vs[1]),
        .vga_blank_n(o_blank_n[1]), .vga_sync_n(o_sync_n[1]), .vga_clk(o_vclk[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(3), .PIX_LATENCY(8), .COLOR_W(8),
        .HS_ACTIVE_HIGH(1'b0), .VS_ACTIVE_HIGH(1'b1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .r_in(r_in[2]), .g_in(g_in[2]), .b_in(b_in[2]),
        .x(ox[2]), .y(oy[2]), .pix_ce(o_pix_ce[2]), .active(o_active[2]),
        .line_start(o_line[2]), .frame_start(o_frame[2]),
        .vga_r(o_r[2]), .vga_g(o_g[2]), .vga_b(o_b[2]), .vga_hs(o_hs[2]), .vga_vs(o_vs[2]),
        .vga_blank_n(o_blank_n[2]), .vga_sync_n(o_sync_n[2]), .vga_clk(o_vclk[2])
    );

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s dut%0d k=%0d: observed %0h expected %0h", tag, d, k, obs, exp);
        end
    endtask

    // Model: k counts clk edges since reset release. Pixel tick n is the
    // pix_ce pulse at k=(n+1)*D; e is the number of ticks already taken,
    // and the pins show the pixel presented PIX_LATENCY+1 ticks earlier.
    task automatic check_dut(input int d, input bit in_rst);
        int ht, vt, e, t, ex, ey, cx, cy, dv;
        bit tick, hb, vb, hsy, vsy;
        logic [23:0] col;
        dv   = CFG_D[d];
        ht   = CFG_HA[d] + CFG_HF[d] + CFG_HS[d] + CFG_HB[d];
        vt   = CFG_VA[d] + CFG_VF[d] + CFG_VS[d] + CFG_VB[d];
        tick = !in_rst && (k > 0) && (k % dv == 0);
        e    = (in_rst || k == 0) ? 0 : (k - 1) / dv;
        ex   = e % ht;
        ey   = (e / ht) % vt;
        check("pix_ce", d, 32'(o_pix_ce[d]), 32'(tick));
        check("vga_clk", d, 32'(o_vclk[d]), 32'(!in_rst && k > 0 && ((k - 1) % dv) >= dv / 2));
        check("x", d, 32'(ox[d]), 32'(ex));
        check("y", d, 32'(oy[d]), 32'(ey));
        check("active", d, 32'(o_active[d]), 32'(!in_rst && ex < CFG_HA[d] && ey < CFG_VA[d]));
        check("line_start", d, 32'(o_line[d]), 32'(tick && ex == 0));
        check("frame_start", d, 32'(o_frame[d]), 32'(tick && ex == 0 && ey == 0));
        t = e - CFG_L[d] - 1;
        if (in_rst || t < 0) begin
            hb = 1'b1; vb = 1'b1; hsy = 1'b0; vsy = 1'b0;
        end else begin
            cx  = t % ht;
            cy  = (t / ht) % vt;
            hb  = cx >= CFG_HA[d];
            vb  = cy >= CFG_VA[d];
            hsy = cx >= CFG_HA[d] + CFG_HF[d] && cx < CFG_HA[d] + CFG_HF[d] + CFG_HS[d];
            vsy = cy >= CFG_VA[d] + CFG_VF[d] && cy < CFG_VA[d] + CFG_VF[d] + CFG_VS[d];
        end
        col = (hb || vb) ? 24'h0 : drv[d];
        check("rgb", d, 32'({o_r[d], o_g[d], o_b[d]}), 32'(col));
        check("vga_hs", d, 32'(o_hs[d]), 32'(hsy ? CFG_HPOL[d] : !CFG_HPOL[d]));
        check("vga_vs", d, 32'(o_vs[d]), 32'(vsy ? CFG_VPOL[d] : !CFG_VPOL[d]));
        check("blank_n", d, 32'(o_blank_n[d]), 32'(!(hb || vb)));
        check("sync_n", d, 32'(o_sync_n[d]), 32'(!(hsy || vsy)));
        // The colour for this tick is driven now and captured at the coming edge.
        if (tick) begin
            drv[d]  = 24'($urandom());
            r_in[d] = drv[d][23:16];
            g_in[d] = drv[d][15:8];
            b_in[d] = drv[d][7:0];
        end
    endtask

    task automatic run_clks(input int n);
        repeat (n) begin
            @(negedge clk);
            k++;
            for (int d = 0; d < NDUT; d++) check_dut(d, 1'b0);
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            drv[d]  = 24'h0;
            r_in[d] = 8'h0;
            g_in[d] = 8'h0;
            b_in[d] = 8'h0;
        end

        // Power-up reset
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) check_dut(d, 1'b1);
        end

        // Release and run several lines (dut1 wraps a line, dut2 many frames)
        rst = 1'b1;
        k   = 0;
        run_clks(6000 + int'($urandom_range(0, 40)));

        // Mid-frame reset held for 3 clk
        rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) check_dut(d, 1'b1);
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) check_dut(d, 1'b1);
        end

        // Restart from x=y=0
        rst = 1'b1;
        k   = 0;
        run_clks(3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
